line_buffer_3x3: RTL and testbench
==================================

LINE_BUFFER_3X3 -- requirements
Module: line_buffer_3x3

Interface
REQ-001 Parameter IMG_W, default 8, pixels per image row (legal range 3..1024).
REQ-002 Parameter IMG_H, default 8, rows per frame (legal range 3..1024).
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 pix_valid  input  1  upstream pixel strobe.
REQ-006 pix_in  input  8 signed  pixel, raster order, row-major, left to right.
REQ-007 pix_ready  output  1  block accepts pix_in this cycle.
REQ-008 win_ready  input  1  downstream 3x3 convolution stage accepts the window.
REQ-009 win_valid  output  1  window outputs hold a valid 3x3 window.
REQ-010 win0..win8  output  8 signed each  window taps; win0/1/2 = top row left/centre/right; win3/4/5 = middle row; win6/7/8 = bottom row.
REQ-011 frame_done  output  1  one-cycle pulse, last pixel of frame accepted.

Function
REQ-012 Pixel accepted ("accept") on a rising edge where pix_valid=1 and pix_ready=1; no other cycle changes pixel state.
REQ-013 pix_ready SHALL equal (!win_valid || win_ready), combinational, no other terms.
REQ-014 Column counter col 0..IMG_W-1 and row counter row 0..IMG_H-1 give the position of the next pixel; on accept col increments, wraps to 0 at IMG_W-1 with row increment; row wraps to 0 at IMG_H-1.
REQ-015 Two line memories of depth IMG_W hold rows r-1 and r-2; on accept at column c, pixel written at index c of row r-1 memory, and the old entry at c moved to index c of row r-2 memory.
REQ-016 3x3 shift register: on accept, each row shifts left one tap; new right column = {row r-2[c], row r-1[c], pix_in} for top/middle/bottom.
REQ-017 Accept at position (r,c) with r>=2 and c>=2 SHALL load win0..win8 with pixels (r-2,c-2..c), (r-1,c-2..c), (r,c-2..c) and set win_valid on that same edge (latency 1 cycle from accept to win_valid visible).
REQ-018 Accept with r<2 or c<2 produces no window; windows never straddle a row wrap or frame wrap.
REQ-019 Exactly (IMG_W-2)*(IMG_H-2) windows per frame, in raster order of their bottom-right pixel.
REQ-020 win_valid=1 and win_ready=0: win_valid and win0..win8 SHALL hold stable; pix_ready=0.
REQ-021 win_valid=1 and win_ready=1 with no window-producing accept: win_valid clears next edge.
REQ-022 win_ready=1 and window-producing accept in same cycle: new window loaded, win_valid stays 1 (back-to-back, no bubble).
REQ-023 frame_done=1 for exactly the cycle after the accept at (IMG_H-1, IMG_W-1), else 0.
REQ-024 Next frame begins immediately with no idle cycle; stale line-memory contents from a previous frame never appear in a window (gated by REQ-018).
REQ-025 Pixels pass through unmodified (no sign change, no saturation); -128 and 127 preserved bit-exact.

Reset
REQ-026 rst=1 at a rising edge: col=0, row=0, win_valid=0, frame_done=0, win0..win8=0; overrides any simultaneous accept.
REQ-027 Line memories need not be cleared; reset mid-frame discards the partial frame and the next accepted pixel is position (0,0).
REQ-028 pix_ready=1 during and immediately after reset.

Verification
REQ-029 IMG_W=IMG_H=4, pixels 0..15 ramp, win_ready=1 -> first window after accept of pixel 10: win0..8 = 0,1,2,4,5,6,8,9,10; total 4 windows (bottom-right 10,11,14,15); frame_done pulse after pixel 15.
REQ-030 Same ramp, win_ready=0 from the first window for 5 cycles -> pix_ready=0, window 0,1,2,4,5,6,8,9,10 held stable 5 cycles, no pixel lost; remaining windows correct after release.
REQ-031 Two frames back-to-back (second ramp 100..115) -> second frame first window 100,101,102,104,105,106,108,109,110; no window mixes frames; 8 windows total.
REQ-032 rst asserted after 7 pixels of a frame, then full ramp 0..15 -> output identical to REQ-029.
REQ-033 Pixel values -128/127 alternating, IMG_W=IMG_H=3 -> single window with taps bit-exact to inputs, win_valid one window only.
REQ-034 Random pix_valid and win_ready, IMG_W=5, IMG_H=4 -> 6 windows, each matching a reference model; win taps never change while win_valid=1 and win_ready=0.

Source files
------------

// File: rtl/line_buffer_3x3.sv
// Raster-order pixel stream to 3x3 sliding window; window visible 1 cycle after the accept of its bottom-right pixel.
// A held window (win_valid && !win_ready) stalls the input: pix_ready is low until the window is taken.
module line_buffer_3x3 #(
  parameter int IMG_W = 8,
  parameter int IMG_H = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pix_valid,
  input  logic signed [7:0] pix_in,
  output logic              pix_ready,
  input  logic              win_ready,
  output logic              win_valid,
  output logic signed [7:0] win0,
  output logic signed [7:0] win1,
  output logic signed [7:0] win2,
  output logic signed [7:0] win3,
  output logic signed [7:0] win4,
  output logic signed [7:0] win5,
  output logic signed [7:0] win6,
  output logic signed [7:0] win7,
  output logic signed [7:0] win8,
  output logic              frame_done
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  logic [CW-1:0]     col;
  logic [RW-1:0]     row;
  logic signed [7:0] line1 [IMG_W];
  logic signed [7:0] line2 [IMG_W];
  logic signed [7:0] tap   [9];
  logic              accept;
  logic              col_last;
  logic              row_last;
  logic              win_load;

  assign pix_ready = !win_valid || win_ready;
  assign accept    = pix_valid && pix_ready;
  assign col_last  = (col == COL_LAST);
  assign row_last  = (row == ROW_LAST);
  // Rows 0-1 and columns 0-1 only prime the buffers, so stale data never forms a window.
  assign win_load  = accept && (row >= RW'(2)) && (col >= CW'(2));

  always_ff @(posedge clk) begin
    if (rst) begin
      col        <= '0;
      row        <= '0;
      win_valid  <= 1'b0;
      frame_done <= 1'b0;
      for (int i = 0; i < 9; i++) tap[i] <= '0;
    end else begin
      frame_done <= accept && col_last && row_last;
      if (win_load) begin
        win_valid <= 1'b1;
      end else if (win_ready) begin
        win_valid <= 1'b0;
      end
      if (accept) begin
        if (col_last) begin
          col <= '0;
          row <= row_last ? '0 : row + RW'(1);
        end else begin
          col <= col + CW'(1);
        end
        tap[0] <= tap[1];
        tap[1] <= tap[2];
        tap[2] <= line2[col];
        tap[3] <= tap[4];
        tap[4] <= tap[5];
        tap[5] <= line1[col];
        tap[6] <= tap[7];
        tap[7] <= tap[8];
        tap[8] <= pix_in;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept && !rst) begin
      line1[col] <= pix_in;
      line2[col] <= line1[col];
    end
  end

  assign win0 = tap[0];
  assign win1 = tap[1];
  assign win2 = tap[2];
  assign win3 = tap[3];
  assign win4 = tap[4];
  assign win5 = tap[5];
  assign win6 = tap[6];
  assign win7 = tap[7];
  assign win8 = tap[8];

endmodule

// File: tb/tb_line_buffer_3x3.sv
// Bench for line_buffer_3x3: three instances (4x4, 3x3, 5x4) driven one at a time against a
// frame-image model whose expected windows are queued at accept and popped when consumed.
module tb_line_buffer_3x3;

  logic        clk = 1'b0;
  logic        rst  [3];
  logic        pv   [3];
  logic        pr   [3];
  logic        wr   [3];
  logic        wv   [3];
  logic        fd   [3];
  logic [7:0]  pin  [3];
  logic [71:0] wout [3];

  initial forever #5 clk = ~clk;

  generate
    for (genvar g = 0; g < 3; g++) begin : g_dut
      line_buffer_3x3 #(
        .IMG_W(g == 1 ? 3 : (g == 2 ? 5 : 4)),
        .IMG_H(g == 1 ? 3 : 4)
      ) u_dut (
        .clk       (clk),
        .rst       (rst[g]),
        .pix_valid (pv[g]),
        .pix_in    (pin[g]),
        .pix_ready (pr[g]),
        .win_ready (wr[g]),
        .win_valid (wv[g]),
        .win0      (wout[g][71:64]),
        .win1      (wout[g][63:56]),
        .win2      (wout[g][55:48]),
        .win3      (wout[g][47:40]),
        .win4      (wout[g][39:32]),
        .win5      (wout[g][31:24]),
        .win6      (wout[g][23:16]),
        .win7      (wout[g][15:8]),
        .win8      (wout[g][7:0]),
        .frame_done(fd[g])
      );
    end
  endgenerate

  localparam logic [71:0] W_FIRST = 72'h00_01_02_04_05_06_08_09_0A;
  localparam logic [71:0] W_LAST  = 72'h05_06_07_09_0A_0B_0D_0E_0F;
  localparam logic [71:0] W_F2    = 72'h64_65_66_68_69_6A_6C_6D_6E;
  localparam logic [71:0] W_33    = 72'h80_7F_80_7F_80_7F_80_7F_80;

  int          total = 0;
  int          bad = 0;
  int          cur = 0;
  int          mr, mc, mw, mh;
  int          fd_set = 0;
  int          fd_seen = 0;
  bit          mon_en = 1'b0;
  bit          rnd_on = 1'b0;
  bit          hold_prev = 1'b0;
  logic [71:0] prev_w;
  logic [7:0]  img [8][8];
  logic [71:0] expq [$];
  logic [71:0] got  [$];

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] expv);
    total++;
    if (obs !== expv) begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [71:0] wexp(input int r, input int c);
    return {img[r-2][c-2], img[r-2][c-1], img[r-2][c],
            img[r-1][c-2], img[r-1][c-1], img[r-1][c],
            img[r][c-2],   img[r][c-1],   img[r][c]};
  endfunction

  task automatic select(input int k, input int w, input int h);
    cur = k; mw = w; mh = h; mr = 0; mc = 0;
    got.delete();
  endtask

  // Present one pixel and wait (bounded) for its accept; the model records it at that edge.
  task automatic send(input int k, input logic [7:0] p);
    bit ok;
    int n;
    ok = 1'b0;
    n = 0;
    pv[k] = 1'b1;
    pin[k] = p;
    while (!ok && n < 300) begin
      @(negedge clk);
      if (pr[k] === 1'b1) ok = 1'b1;
      else n++;
    end
    chk("send_accept", ok, 1'b1);
    if (ok) begin
      @(posedge clk);
      img[mr][mc] = p;
      if (mr >= 2 && mc >= 2) expq.push_back(wexp(mr, mc));
      if (mr == mh - 1 && mc == mw - 1) fd_set++;
      if (mc == mw - 1) begin
        mc = 0;
        mr = (mr == mh - 1) ? 0 : mr + 1;
      end else begin
        mc++;
      end
      #1;
    end
  endtask

  task automatic send_ramp(input int k, input int base, input int n);
    for (int i = 0; i < n; i++) send(k, 8'(base + i));
  endtask

  task automatic idle(input int k, input int n);
    pv[k] = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int hn;
    for (int k = 0; k < 3; k++) begin
      rst[k] = 1'b1; pv[k] = 1'b0; wr[k] = 1'b1; pin[k] = '0;
    end
    select(0, 4, 4);

    fork
      forever begin
        @(negedge clk);
        if (mon_en) begin
          chk("pix_ready", pr[cur], (!wv[cur] || wr[cur]));
          chk("frame_done", fd[cur], (fd_set != fd_seen));
          fd_seen = fd_set;
          if (hold_prev) begin
            chk("hold_valid", wv[cur], 1'b1);
            chk("hold_taps", wout[cur], prev_w);
          end
          hold_prev = (wv[cur] === 1'b1) && (wr[cur] === 1'b0);
          prev_w = wout[cur];
          if (wv[cur] === 1'b1 && wr[cur] === 1'b1) begin
            got.push_back(wout[cur]);
            chk("window_expected", (expq.size() > 0), 1'b1);
            if (expq.size() > 0) chk("window_taps", wout[cur], expq.pop_front());
          end
        end
      end
    join_none

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk("rst_win_valid", wv[k], 1'b0);
      chk("rst_frame_done", fd[k], 1'b0);
      chk("rst_taps", wout[k], 72'h0);
      chk("rst_pix_ready", pr[k], 1'b1);
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) rst[k] = 1'b0;
    mon_en = 1'b1;

    // Ramp 0..15, always ready
    send_ramp(0, 0, 16);
    idle(0, 6);
    chk("ramp_count", got.size(), 4);
    chk("ramp_first", got[0], W_FIRST);
    chk("ramp_last", got[3], W_LAST);
    chk("ramp_drained", expq.size(), 0);

    // Downstream stalls the first window for 5 cycles
    select(0, 4, 4);
    wr[0] = 1'b0;
    fork
      begin
        send_ramp(0, 0, 16);
        idle(0, 1);
      end
      begin
        hn = 0;
        while (wv[0] !== 1'b1 && hn < 200) begin
          @(negedge clk);
          hn++;
        end
        chk("stall_seen", wv[0], 1'b1);
        for (int i = 0; i < 5; i++) begin
          chk("stall_pix_ready", pr[0], 1'b0);
          chk("stall_window", wout[0], W_FIRST);
          @(negedge clk);
        end
        @(posedge clk);
        #1;
        wr[0] = 1'b1;
      end
    join
    idle(0, 6);
    chk("stall_count", got.size(), 4);
    chk("stall_first", got[0], W_FIRST);
    chk("stall_last", got[3], W_LAST);
    chk("stall_drained", expq.size(), 0);

    // Two frames back to back
    select(0, 4, 4);
    send_ramp(0, 0, 16);
    send_ramp(0, 100, 16);
    idle(0, 6);
    chk("two_frame_count", got.size(), 8);
    chk("two_frame_f2_first", got[4], W_F2);
    chk("two_frame_drained", expq.size(), 0);

    // Reset mid-frame (with a pixel offered during reset), then a clean ramp
    select(0, 4, 4);
    send_ramp(0, 0, 7);
    pin[0] = 8'd77;
    rst[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_win_valid", wv[0], 1'b0);
    chk("midrst_taps", wout[0], 72'h0);
    chk("midrst_pix_ready", pr[0], 1'b1);
    @(posedge clk);
    #1;
    rst[0] = 1'b0;
    pv[0] = 1'b0;
    mr = 0;
    mc = 0;
    send_ramp(0, 0, 16);
    idle(0, 6);
    chk("midrst_count", got.size(), 4);
    chk("midrst_first", got[0], W_FIRST);
    chk("midrst_last", got[3], W_LAST);

    // 3x3 extremes
    select(1, 3, 3);
    for (int i = 0; i < 9; i++) send(1, (i % 2 == 0) ? 8'h80 : 8'h7F);
    idle(1, 6);
    chk("ext_count", got.size(), 1);
    chk("ext_window", got[0], W_33);

    // 5x4 with random gaps and random downstream ready
    select(2, 5, 4);
    rnd_on = 1'b1;
    fork
      begin
        while (rnd_on) begin
          @(posedge clk);
          #1;
          wr[2] = ($urandom_range(0, 2) != 0);
        end
        wr[2] = 1'b1;
      end
    join_none
    for (int i = 0; i < 20; i++) begin
      hn = $urandom_range(0, 2);
      if (hn > 0) idle(2, hn);
      send(2, 8'($urandom));
    end
    rnd_on = 1'b0;
    idle(2, 10);
    chk("rand_count", got.size(), 6);
    chk("rand_drained", expq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
